// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state codes and default parameters for the reset sequencer
package reset_sequencer_pkg;

  localparam int DEFAULT_NUM_STAGES   = 4;
  localparam int DEFAULT_STAGE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_HOLD      = 2'd3
  } state_t;

endpackage

// File: rtl/positive_edge_detector.sv
// rtl/positive_edge_detector.sv - rising-edge detector on a level input
module positive_edge_detector (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // Remember the previous sampled level; cleared on reset so a level already high counts as a new edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged release of downstream reset domains with software reset and lock tracking
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES   = DEFAULT_NUM_STAGES,
  parameter int STAGE_CYCLES = DEFAULT_STAGE_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  locked_i,
  input  logic                  sw_reset_req_i,
  output logic                  sw_reset_ack_o,
  output logic [NUM_STAGES-1:0] stage_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  localparam logic [7:0]            CNT_LAST = 8'(STAGE_CYCLES - 1);
  localparam logic [2:0]            IDX_LAST = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_ON   = '1;

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic [2:0]            r_idx;
  logic [NUM_STAGES-1:0] r_stage;
  logic                  r_ack;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_sw_rise;
  logic [NUM_STAGES-1:0] w_keep_mask;

  positive_edge_detector u_sw_edge (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_sig   (sw_reset_req_i),
    .o_rise  (w_sw_rise)
  );

  // Every bit except the stage currently being released.
  assign w_keep_mask = ~(NUM_STAGES'(1) << r_idx);

  // Sequencer FSM: reset, then lock loss, then software request, then normal counting.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_WAIT_LOCK;
      r_stage <= ALL_ON;
      r_cnt   <= 8'd0;
      r_idx   <= 3'd0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (!locked_i) begin
        // Lost (or not yet gained) lock: slam every domain back into reset.
        r_state <= ST_WAIT_LOCK;
        r_stage <= ALL_ON;
        r_cnt   <= 8'd0;
        r_idx   <= 3'd0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT_LOCK: begin
            r_state <= ST_RELEASE;
            r_cnt   <= 8'd0;
            r_idx   <= 3'd0;
          end
          ST_RELEASE: begin
            if (r_cnt == CNT_LAST) begin
              r_stage <= r_stage & w_keep_mask;
              r_cnt   <= 8'd0;
              if (r_idx == IDX_LAST) begin
                r_state <= ST_RUN;
                r_idx   <= 3'd0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          ST_RUN: begin
            if (w_sw_rise) begin
              r_state <= ST_HOLD;
              r_stage <= ALL_ON;
              r_cnt   <= 8'd0;
              r_ack   <= 1'b1;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_WAIT_LOCK;
              r_cnt   <= 8'd0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          default: begin
            r_state <= ST_WAIT_LOCK;
            r_stage <= ALL_ON;
            r_cnt   <= 8'd0;
            r_idx   <= 3'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sw_reset_ack_o = r_ack;
  assign stage_reset_o  = r_stage;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign state_o        = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer (default and minimum configurations)
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, locked_i, sw_req;

  logic       ack0, busy0, done0;
  logic [3:0] stage0;
  logic [1:0] state0;
  logic       ack1, busy1, done1;
  logic [0:0] stage1;
  logic [1:0] state1;

  reset_sequencer #(.NUM_STAGES(4), .STAGE_CYCLES(16)) u_dut0 (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .locked_i       (locked_i),
    .sw_reset_req_i (sw_req),
    .sw_reset_ack_o (ack0),
    .stage_reset_o  (stage0),
    .busy_o         (busy0),
    .done_o         (done0),
    .state_o        (state0)
  );

  reset_sequencer #(.NUM_STAGES(1), .STAGE_CYCLES(2)) u_dut1 (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .locked_i       (locked_i),
    .sw_reset_req_i (sw_req),
    .sw_reset_ack_o (ack1),
    .stage_reset_o  (stage1),
    .busy_o         (busy1),
    .done_o         (done1),
    .state_o        (state1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode uses the published state codes, t is cycles elapsed in the current phase.
  int ns[2] = '{4, 1};
  int sc[2] = '{16, 2};
  int m_mode[2];
  int m_t[2];
  bit m_ack[2];
  bit m_prev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise;
    rise = sw_req && !m_prev;
    for (int i = 0; i < 2; i++) begin
      m_ack[i] = 1'b0;
      if (reset_i || !locked_i) begin
        m_mode[i] = 0;
        m_t[i]    = 0;
      end else begin
        case (m_mode[i])
          0: begin m_mode[i] = 1; m_t[i] = 0; end
          1: begin
            m_t[i]++;
            if (m_t[i] == ns[i] * sc[i]) m_mode[i] = 2;
          end
          2: if (rise) begin m_mode[i] = 3; m_t[i] = 0; m_ack[i] = 1'b1; end
          default: begin
            m_t[i]++;
            if (m_t[i] == sc[i]) begin m_mode[i] = 0; m_t[i] = 0; end
          end
        endcase
      end
    end
    m_prev = reset_i ? 1'b0 : sw_req;
  endtask

  // Stage k is held while releasing until (k+1)*STAGE_CYCLES cycles have elapsed.
  function automatic logic [31:0] exp_stage(int i);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < ns[i]; k++)
      if (m_mode[i] != 2 && (m_mode[i] != 1 || m_t[i] < (k + 1) * sc[i])) v[k] = 1'b1;
    return v;
  endfunction

  task automatic compare_all();
    check_eq("stage0", 32'(stage0), exp_stage(0));
    check_eq("ack0",   32'(ack0),   32'(m_ack[0]));
    check_eq("busy0",  32'(busy0),  32'(m_mode[0] != 2));
    check_eq("done0",  32'(done0),  32'(m_mode[0] == 2));
    check_eq("state0", 32'(state0), 32'(m_mode[0]));
    check_eq("stage1", 32'(stage1), exp_stage(1));
    check_eq("ack1",   32'(ack1),   32'(m_ack[1]));
    check_eq("busy1",  32'(busy1),  32'(m_mode[1] != 2));
    check_eq("done1",  32'(done1),  32'(m_mode[1] == 2));
    check_eq("state1", 32'(state1), 32'(m_mode[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_done(output int d0, output int d1, input int n0, input int limit);
    int n;
    n  = n0;
    d0 = -1;
    d1 = -1;
    while ((d0 < 0 || d1 < 0) && n < limit) begin
      step();
      n++;
      if (d0 < 0 && done0) d0 = n;
      if (d1 < 0 && done1) d1 = n;
    end
  endtask

  task automatic wait_release_t(input int t, input int limit);
    int n;
    n = 0;
    while (!(m_mode[0] == 1 && m_t[0] == t) && n < limit) begin
      step();
      n++;
    end
    check_eq("wait_release_timeout", 32'(n < limit), 32'd1);
  endtask

  initial begin
    int d0, d1, n;
    bit lk;
    reset_i  = 1'b1;
    locked_i = 1'b1;
    sw_req   = 1'b0;
    m_mode   = '{0, 0};
    m_t      = '{0, 0};
    m_ack    = '{0, 0};
    m_prev   = 1'b0;

    // Power-up: reset for 3 cycles with lock already present.
    repeat (3) step();
    check_eq("reset_stage0", 32'(stage0), 32'hF);
    check_eq("reset_state0", 32'(state0), 32'd0);
    reset_i = 1'b0;
    step();
    check_eq("rel_entry0", 32'(state0), 32'd1);
    check_eq("rel_entry1", 32'(state1), 32'd1);
    wait_done(d0, d1, 0, 200);
    check_eq("rel_to_done0", 32'(d0), 32'd64);
    check_eq("rel_to_done1", 32'(d1), 32'd2);

    // Software reset from RUN.
    sw_req = 1'b1;
    step();
    check_eq("sw_ack0", 32'(ack0), 32'd1);
    check_eq("sw_ack1", 32'(ack1), 32'd1);
    sw_req = 1'b0;
    wait_done(d0, d1, 0, 200);
    check_eq("ack_to_done0", 32'(d0), 32'(16 + 1 + 4 * 16));
    check_eq("ack_to_done1", 32'(d1), 32'(2 + 1 + 1 * 2));

    // Lock loss at cnt=7 of stage 2, then relock.
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    wait_release_t(2 * 16 + 7, 300);
    locked_i = 1'b0;
    step();
    check_eq("lockloss_stage0", 32'(stage0), 32'hF);
    check_eq("lockloss_state0", 32'(state0), 32'd0);
    repeat (3) step();
    locked_i = 1'b1;
    step();
    check_eq("relock_state0", 32'(state0), 32'd1);
    repeat (16) step();
    check_eq("relock_stage0", 32'(stage0), 32'hE);

    // Request pulse during RELEASE is discarded; a level held across RUN entry is not an edge.
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    step();
    check_eq("rel_req_state0", 32'(state0), 32'd1);
    sw_req = 1'b1;
    wait_done(d0, d1, 0, 100);
    check_eq("held_done0", 32'(done0), 32'd1);
    repeat (5) begin
      step();
      check_eq("held_req_ack0", 32'(ack0), 32'd0);
    end
    sw_req = 1'b0;
    step();

    // Reset pulse in HOLD at cnt=5.
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    repeat (5) step();
    check_eq("hold_state0", 32'(state0), 32'd3);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_eq("midrst_stage0", 32'(stage0), 32'hF);
    check_eq("midrst_state0", 32'(state0), 32'd0);
    check_eq("midrst_busy0",  32'(busy0),  32'd1);
    check_eq("midrst_done0",  32'(done0),  32'd0);
    check_eq("midrst_ack0",   32'(ack0),   32'd0);

    // Randomized traffic against the model.
    lk = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      reset_i = ($urandom_range(0, 999) < 3);
      if (lk && $urandom_range(0, 999) < 4) lk = 1'b0;
      else if (!lk && $urandom_range(0, 99) < 25) lk = 1'b1;
      locked_i = lk;
      n = $urandom_range(0, 99);
      if (n < 12) sw_req = ~sw_req;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of downstream reset domains, legal range 1-8.
REQ-002 Parameter STAGE_CYCLES, default 16, clk_i cycles per release/hold step, legal range 2-255.
REQ-003 clk_i  input  1  single system clock; all logic on posedge.
REQ-004 reset_i  input  1  reset, synchronous and active-high.
REQ-005 locked_i  input  1  upstream clock/reset controller locked; high means the clock is stable.
REQ-006 sw_reset_req_i  input  1  software reset request, level; only the rising edge acts.
REQ-007 sw_reset_ack_o  output  1  one-cycle pulse when a software request is accepted.
REQ-008 stage_reset_o  output  NUM_STAGES  per-domain active-high resets; bit 0 is released first.
REQ-009 busy_o  output  1  high in every state except RUN.
REQ-010 done_o  output  1  high only in RUN, meaning all stages are released.
REQ-011 state_o  output  2  current FSM state code, for debug.

Function
REQ-012 FSM states and codes: WAIT_LOCK=0, RELEASE=1, RUN=2, HOLD=3.
REQ-013 All outputs shall be registered.
REQ-014 Internal storage: 8-bit step counter cnt and 3-bit stage index idx.
REQ-015 WAIT_LOCK behaviour:
  - stage_reset_o is all ones.
  - When locked_i is sampled high, the FSM moves to RELEASE with cnt=0 and idx=0.
REQ-016 RELEASE behaviour:
  - cnt increments every cycle.
  - When cnt==STAGE_CYCLES-1: stage_reset_o[idx] clears, cnt returns to 0, idx increments.
  - Stage k therefore deasserts exactly (k+1)*STAGE_CYCLES cycles after the edge that entered RELEASE.
REQ-017 When the last stage (idx==NUM_STAGES-1) reaches terminal count, the FSM enters RUN on the same edge that clears the last bit.
REQ-018 RUN behaviour: stage_reset_o is all zeros, done_o=1, busy_o=0.
REQ-019 Rising-edge detection of sw_reset_req_i has 1-cycle latency (registered previous value).
REQ-020 A rising edge detected in RUN causes, on the same edge:
  - entry to HOLD;
  - stage_reset_o set to all ones;
  - sw_reset_ack_o pulsed for exactly one cycle;
  - cnt cleared.
REQ-021 HOLD behaviour:
  - Hold all resets asserted for STAGE_CYCLES cycles, then enter WAIT_LOCK.
  - If locked_i is still high, WAIT_LOCK exits on the next edge.
REQ-022 Rising edges of sw_reset_req_i outside RUN shall be discarded: no ack, and not queued.
REQ-023 If locked_i is sampled low in RELEASE, RUN or HOLD:
  - next state is WAIT_LOCK;
  - stage_reset_o is all ones;
  - cnt and idx are cleared;
  - no ack is issued.
REQ-024 Priority on any edge: reset_i, then loss of locked_i, then software request, then normal counting.
REQ-025 A software request on the same cycle that locked_i drops shall be dropped.
REQ-026 cnt shall never exceed STAGE_CYCLES-1, and idx shall never exceed NUM_STAGES-1.

Reset
REQ-027 With reset_i high at a posedge, the block shall load:
  - state WAIT_LOCK;
  - stage_reset_o all ones;
  - cnt=0, idx=0;
  - sw_reset_ack_o=0, busy_o=1, done_o=0, state_o=0;
  - edge-detect register=0.
REQ-028 reset_i asserted mid-RELEASE or mid-HOLD shall abort the sequence and reload those values on that edge.

Structure
REQ-029 State codes and the default parameter values shall live in shared package reset_sequencer_pkg.
REQ-030 Rising-edge detection of sw_reset_req_i shall use the existing positive_edge_detector sub-module, clocked by clk_i and reset by reset_i.
REQ-031 No other sub-modules; target 120-250 lines of RTL.

Verification (NUM_STAGES=4, STAGE_CYCLES=16)
REQ-032 Power-up release:
  - Stimulus: reset_i high for 3 cycles; locked_i high from cycle 0.
  - Required: stage_reset_o steps 1111 -> 1110 -> 1100 -> 1000 -> 0000 at 16-cycle spacing.
  - Required: done_o rises with the 0000 step, 64 cycles after RELEASE entry.
REQ-033 Software reset:
  - Stimulus: sw_reset_req_i 0->1 while in RUN.
  - Required: ack pulse 1 cycle wide; stage_reset_o=1111 for 16 cycles.
  - Required: full release sequence repeats, with done_o high again 81 cycles after the ack.
REQ-034 Lock loss:
  - Stimulus: locked_i drops at cnt=7 of stage 2.
  - Required: next cycle stage_reset_o=1111 and state_o=0.
  - Required: relocking restarts from stage 0.
REQ-035 Ignored and held requests:
  - Stimulus: sw_reset_req_i pulse during RELEASE.
  - Required: no ack and no HOLD.
  - Stimulus: sw_reset_req_i held high across RUN entry.
  - Required: no ack, because there is no new rising edge.
REQ-036 Mid-sequence reset:
  - Stimulus: reset_i pulsed during HOLD cnt=5.
  - Required: all outputs return to REQ-027 values on the following cycle.
REQ-037 Boundary: with STAGE_CYCLES=2 and NUM_STAGES=1, done_o shall rise 2 cycles after RELEASE entry.
